// File: rtl/spatz_issue_scoreboard.sv
// spatz_issue_scoreboard: in-order issue queue with a vector-register
// write scoreboard between the Spatz controller and VFU/LSU/SLD.
// Optional build macro SPATZ_SB_BYPASS_EN: the hazard check ignores busy
// bits being cleared by this cycle's completions, so a dependent head can
// issue in the same cycle as its producer's completion.
// Handshakes: a transfer happens on a rising edge where valid && ready;
// once issue_valid_o is high it holds with stable id/payload until taken.
module spatz_issue_scoreboard #(
   parameter int DEPTH = 4,
   parameter int ID_W  = 3,
   parameter int PLD_W = 64
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               req_valid_i,
   output logic               req_ready_o,
   input  logic [1:0]         req_unit_i,
   input  logic [4:0]         req_vd_i,
   input  logic [4:0]         req_vs1_i,
   input  logic [4:0]         req_vs2_i,
   input  logic               req_use_vd_i,
   input  logic               req_use_vs1_i,
   input  logic               req_use_vs2_i,
   input  logic [ID_W-1:0]    req_id_i,
   input  logic [PLD_W-1:0]   req_payload_i,
   output logic [2:0]         issue_valid_o,
   input  logic [2:0]         issue_ready_i,
   output logic [ID_W-1:0]    issue_id_o,
   output logic [PLD_W-1:0]   issue_payload_o,
   input  logic [2:0]         rsp_valid_i,
   input  logic [3*ID_W-1:0]  rsp_id_i,
   output logic [31:0]        busy_o,
   output logic               idle_o
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int NID   = 1 << ID_W;

   typedef struct packed {
      logic [1:0]       unit;
      logic [4:0]       vd;
      logic [4:0]       vs1;
      logic [4:0]       vs2;
      logic             use_vd;
      logic             use_vs1;
      logic             use_vs2;
      logic [ID_W-1:0]  id;
      logic [PLD_W-1:0] payload;
   } entry_t;

   entry_t           mem_q [DEPTH];
   entry_t           mem_d [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      busy_q, busy_d;
   logic [NID-1:0]   pend_q, pend_d, vdv_q, vdv_d;
   logic [4:0]       vd_tab_q [NID];
   logic [4:0]       vd_tab_d [NID];

   entry_t      head;
   logic        empty, full, push_acc, push, pop, hazard;
   logic [31:0] clr_vec, busy_chk;
   logic [NID-1:0] pend_clr;

   assign head        = mem_q[rd_ptr_q];
   assign empty       = (cnt_q == '0);
   assign full        = (cnt_q == CNT_W'(DEPTH));
   assign req_ready_o = !full;
   assign push_acc    = req_valid_i && req_ready_o;
   // Unit 3 is accepted upstream-visible but never stored.
   assign push        = push_acc && (req_unit_i != 2'd3);
   assign busy_o      = busy_q;
   assign idle_o      = empty && (pend_q == '0);
   assign issue_id_o      = empty ? '0 : head.id;
   assign issue_payload_o = empty ? '0 : head.payload;

   // Completion decode: pending ids retire, and their recorded vd is freed.
   always_comb begin
      clr_vec  = '0;
      pend_clr = '0;
      for (int k = 0; k < 3; k++) begin
         if (rsp_valid_i[k] && pend_q[rsp_id_i[k*ID_W +: ID_W]]) begin
            pend_clr[rsp_id_i[k*ID_W +: ID_W]] = 1'b1;
            if (vdv_q[rsp_id_i[k*ID_W +: ID_W]])
               clr_vec[vd_tab_q[rsp_id_i[k*ID_W +: ID_W]]] = 1'b1;
         end
      end
   end

`ifdef SPATZ_SB_BYPASS_EN
   assign busy_chk = busy_q & ~clr_vec;
`else
   assign busy_chk = busy_q;
`endif

   assign hazard = (head.use_vs1 && busy_chk[head.vs1]) ||
                   (head.use_vs2 && busy_chk[head.vs2]) ||
                   (head.use_vd  && busy_chk[head.vd]);

   // Present the head to its target unit when it is hazard-free.
   always_comb begin
      issue_valid_o = 3'b000;
      if (!empty && !hazard) begin
         case (head.unit)
            2'd0:    issue_valid_o = 3'b001;
            2'd1:    issue_valid_o = 3'b010;
            2'd2:    issue_valid_o = 3'b100;
            default: issue_valid_o = 3'b000;
         endcase
      end
   end

   assign pop = |(issue_valid_o & issue_ready_i);

   // Next-state for queue storage, pointers, count and scoreboard.
   always_comb begin
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      cnt_d    = cnt_q;
      vd_tab_d = vd_tab_q;
      vdv_d    = vdv_q;
      busy_d   = busy_q & ~clr_vec;
      pend_d   = pend_q & ~pend_clr;
      if (push) begin
         mem_d[wr_ptr_q] = '{unit: req_unit_i, vd: req_vd_i, vs1: req_vs1_i,
                             vs2: req_vs2_i, use_vd: req_use_vd_i,
                             use_vs1: req_use_vs1_i, use_vs2: req_use_vs2_i,
                             id: req_id_i, payload: req_payload_i};
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
         // Issue sets are applied after clears so a set always wins.
         pend_d[head.id] = 1'b1;
         vdv_d[head.id]  = head.use_vd;
         if (head.use_vd) begin
            busy_d[head.vd]   = 1'b1;
            vd_tab_d[head.id] = head.vd;
         end
      end
      if (push && !pop)
         cnt_d = cnt_q + CNT_W'(1);
      else if (!push && pop)
         cnt_d = cnt_q - CNT_W'(1);
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         for (int i = 0; i < NID; i++) vd_tab_q[i] <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
         busy_q   <= '0;
         pend_q   <= '0;
         vdv_q    <= '0;
      end else begin
         mem_q    <= mem_d;
         vd_tab_q <= vd_tab_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
         pend_q   <= pend_d;
         vdv_q    <= vdv_d;
      end
   end
endmodule

// File: tb/tb_spatz_issue_scoreboard.sv
// Directed bench for spatz_issue_scoreboard with an expected-issue queue.
// Build with SPATZ_SB_BYPASS_EN to check the same-cycle completion bypass.
module tb_spatz_issue_scoreboard;
   localparam int ID_W  = 3;
   localparam int PLD_W = 64;
   localparam int EW    = 3 + ID_W + PLD_W;
`ifdef SPATZ_SB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic              clk, rst;
   logic              req_valid, req_ready;
   logic [1:0]        req_unit;
   logic [4:0]        req_vd, req_vs1, req_vs2;
   logic              req_use_vd, req_use_vs1, req_use_vs2;
   logic [ID_W-1:0]   req_id;
   logic [PLD_W-1:0]  req_payload;
   logic [2:0]        issue_valid, issue_ready;
   logic [ID_W-1:0]   issue_id;
   logic [PLD_W-1:0]  issue_payload;
   logic [2:0]        rsp_valid;
   logic [3*ID_W-1:0] rsp_id;
   logic [31:0]       busy;
   logic              idle;

   int             n_vec = 0;
   int             n_err = 0;
   logic [EW-1:0]  exp_q[$];
   logic [7:0]     tb_out;

   spatz_issue_scoreboard #(.DEPTH(4), .ID_W(ID_W), .PLD_W(PLD_W)) dut (
      .clk_i(clk), .rst_i(rst),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_unit_i(req_unit),
      .req_vd_i(req_vd), .req_vs1_i(req_vs1), .req_vs2_i(req_vs2),
      .req_use_vd_i(req_use_vd), .req_use_vs1_i(req_use_vs1),
      .req_use_vs2_i(req_use_vs2), .req_id_i(req_id),
      .req_payload_i(req_payload), .issue_valid_o(issue_valid),
      .issue_ready_i(issue_ready), .issue_id_o(issue_id),
      .issue_payload_o(issue_payload), .rsp_valid_i(rsp_valid),
      .rsp_id_i(rsp_id), .busy_o(busy), .idle_o(idle)
   );

   // Clock and reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Driver: offer one request for one cycle; legal ones become expected issues.
   task automatic push(input logic [1:0] unit, input logic [4:0] vd, input logic uvd,
                       input logic [4:0] vs1, input logic uvs1,
                       input logic [4:0] vs2, input logic uvs2,
                       input logic [ID_W-1:0] id);
      logic [PLD_W-1:0] p;
      logic [2:0] oh;
      p  = {$urandom, $urandom};
      oh = 3'b001 << unit;
      if (unit != 2'd3) check("id_reuse", EW'(tb_out[id]), '0);
      req_unit = unit; req_vd = vd; req_use_vd = uvd;
      req_vs1 = vs1; req_use_vs1 = uvs1; req_vs2 = vs2; req_use_vs2 = uvs2;
      req_id = id; req_payload = p; req_valid = 1'b1;
      cyc(1);
      req_valid = 1'b0;
      if (unit != 2'd3) begin
         exp_q.push_back({oh, id, p});
         tb_out[id] = 1'b1;
      end
   endtask

   task automatic rsp_drive(input logic [2:0] v, input logic [ID_W-1:0] a,
                            input logic [ID_W-1:0] b, input logic [ID_W-1:0] c);
      rsp_valid = v;
      rsp_id = {c, b, a};
      if (v[0]) tb_out[a] = 1'b0;
      if (v[1]) tb_out[b] = 1'b0;
      if (v[2]) tb_out[c] = 1'b0;
   endtask

   task automatic rsp_pulse(input logic [2:0] v, input logic [ID_W-1:0] a,
                            input logic [ID_W-1:0] b, input logic [ID_W-1:0] c);
      rsp_drive(v, a, b, c);
      cyc(1);
      rsp_valid = 3'b000;
   endtask

   // Scoreboard: every issue handshake must match the oldest expected entry.
   always @(negedge clk) begin
      if (!rst && ((issue_valid & issue_ready) != 3'b000)) begin
         if (exp_q.size() == 0)
            check("unexpected_issue", {issue_valid, issue_id, issue_payload}, '0);
         else
            check("issue", {issue_valid, issue_id, issue_payload}, exp_q.pop_front());
      end
   end

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_unit = '0; req_vd = '0; req_vs1 = '0;
      req_vs2 = '0; req_use_vd = 1'b0; req_use_vs1 = 1'b0; req_use_vs2 = 1'b0;
      req_id = '0; req_payload = '0; issue_ready = 3'b111; rsp_valid = 3'b000;
      rsp_id = '0; tb_out = '0;
      cyc(2);
      rst = 1'b0;
      check("rst_idle", EW'(idle), 1);
      check("rst_busy", EW'(busy), 0);
      check("rst_valid", EW'(issue_valid), 0);
      check("rst_ready", EW'(req_ready), 1);
      check("rst_id_pld", {issue_id, issue_payload}, 0);

      // RAW stall on v4
      push(2'd0, 5'd4, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 3'd0);
      check("raw_v0", EW'(issue_valid), 3'b001);
      push(2'd0, 5'd0, 1'b0, 5'd4, 1'b1, 5'd0, 1'b0, 3'd1);
      check("raw_busy4", EW'(busy), 32'h10);
      check("raw_hold", EW'(issue_valid), 0);
      cyc(2);
      check("raw_hold2", EW'(issue_valid), 0);
      rsp_drive(3'b001, 3'd0, 3'd0, 3'd0);
      check("raw_cmpl_cycle", EW'(issue_valid), BYP ? 3'b001 : 3'b000);
      cyc(1);
      rsp_valid = 3'b000;
      check("raw_busy_clr", EW'(busy), 0);
      check("raw_after", EW'(issue_valid), BYP ? 3'b000 : 3'b001);
      cyc(1);
      rsp_pulse(3'b001, 3'd1, 3'd0, 3'd0);
      check("raw_idle", EW'(idle), 1);
      check("raw_drained", EW'(exp_q.size()), 0);

      // Full queue with LSU stalled, then back-to-back drain
      issue_ready = 3'b000;
      for (int i = 2; i < 6; i++)
         push(2'd1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, ID_W'(i));
      check("full_ready", EW'(req_ready), 0);
      check("full_head", {issue_valid, issue_id}, {3'b010, 3'd2});
      issue_ready = 3'b111;
      check("full_ready_pop", EW'(req_ready), 0);
      cyc(1);
      check("full_ready_after", EW'(req_ready), 1);
      cyc(3);
      check("full_empty", EW'(issue_valid), 0);
      check("full_pend", EW'(idle), 0);
      check("full_drained", EW'(exp_q.size()), 0);
      rsp_pulse(3'b111, 3'd2, 3'd3, 3'd4);
      rsp_pulse(3'b010, 3'd0, 3'd5, 3'd0);
      check("full_idle", EW'(idle), 1);

      // Three simultaneous completions, plus a vs2 dependent
      push(2'd0, 5'd8, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 3'd1);
      push(2'd1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 3'd2);
      push(2'd2, 5'd10, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 3'd3);
      cyc(1);
      check("sim_busy", EW'(busy), 32'h700);
      push(2'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 3'd4);
      check("vs2_hold", EW'(issue_valid), 0);
      rsp_drive(3'b111, 3'd1, 3'd2, 3'd3);
      check("sim_cmpl_cycle", EW'(issue_valid), BYP ? 3'b001 : 3'b000);
      cyc(1);
      rsp_valid = 3'b000;
      check("sim_busy_clr", EW'(busy), 0);
      check("sim_after", EW'(issue_valid), BYP ? 3'b000 : 3'b001);
      cyc(1);
      rsp_pulse(3'b001, 3'd4, 3'd0, 3'd0);
      check("sim_idle", EW'(idle), 1);

      // Spurious completion and a store without vd
      push(2'd0, 5'd12, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 3'd6);
      cyc(1);
      check("sp_busy", EW'(busy), 32'h1000);
      rsp_pulse(3'b001, 3'd5, 3'd0, 3'd0);
      check("sp_busy_kept", EW'(busy), 32'h1000);
      check("sp_not_idle", EW'(idle), 0);
      push(2'd1, 5'd12, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 3'd7);
      cyc(1);
      check("st_issued", EW'(exp_q.size()), 0);
      check("st_busy", EW'(busy), 32'h1000);
      rsp_pulse(3'b010, 3'd0, 3'd7, 3'd0);
      check("st_cmpl_busy", EW'(busy), 32'h1000);
      rsp_pulse(3'b001, 3'd6, 3'd0, 3'd0);
      check("sp_final", {busy, idle}, {32'h0, 1'b1});

      // Stability under backpressure, illegal unit dropped
      issue_ready = 3'b000;
      push(2'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 3'd0);
      for (int i = 0; i < 10; i++) begin
         check("stable", {issue_valid, issue_id, issue_payload}, exp_q[0]);
         cyc(1);
      end
      check("ill_ready", EW'(req_ready), 1);
      push(2'd3, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 3'd1);
      push(2'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 3'd2);
      push(2'd2, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 3'd3);
      check("ill_not_counted", EW'(req_ready), 1);
      push(2'd1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 3'd4);
      check("ill_full", EW'(req_ready), 0);
      issue_ready = 3'b111;
      cyc(5);
      check("ill_drained", {issue_valid, 32'(exp_q.size())}, '0);
      rsp_pulse(3'b111, 3'd0, 3'd2, 3'd3);
      rsp_pulse(3'b001, 3'd4, 3'd0, 3'd0);
      check("ill_idle", EW'(idle), 1);

      // Reset with three queued entries and one outstanding write
      push(2'd0, 5'd20, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 3'd5);
      cyc(1);
      check("pre_rst_busy", EW'(busy), 32'h0010_0000);
      issue_ready = 3'b000;
      push(2'd0, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 3'd6);
      push(2'd1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 3'd7);
      push(2'd2, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 3'd0);
      rst = 1'b1;
      cyc(2);
      rst = 1'b0;
      exp_q.delete();
      tb_out = '0;
      check("rst2_idle", EW'(idle), 1);
      check("rst2_busy", EW'(busy), 0);
      check("rst2_valid", EW'(issue_valid), 0);
      check("rst2_ready", EW'(req_ready), 1);
      check("rst2_id_pld", {issue_id, issue_payload}, 0);
      issue_ready = 3'b111;
      rsp_pulse(3'b001, 3'd5, 3'd0, 3'd0);
      check("rst2_late_rsp", {busy, idle, issue_valid}, {32'h0, 1'b1, 3'b000});

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/spatz_issue_scoreboard.md
# spatz_issue_scoreboard

In-order issue queue with a vector-register scoreboard, placed between the Spatz controller and the execution units (VFU, LSU, SLD). It buffers accepted vector instructions and dispatches each to its target unit. An instruction is held back while any vector register it reads or writes has a write still outstanding. Outstanding writes are retired by per-unit completion responses tagged with the instruction id.

## Interface
- `DEPTH`, 4: queue entries, power of two, ≥2.
- `ID_W`, 3: instruction id width; at most 2^ID_W ids outstanding.
- `PLD_W`, 64: opaque payload width (decoded request bits), passed through untouched.

- `clk_i`  in  1  clock; all state updates on rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `req_valid_i`  in  1  new instruction offered.
- `req_ready_o`  out  1  queue can accept; equals `!full`.
- `req_unit_i`  in  2  target unit: 0 VFU, 1 LSU, 2 SLD; 3 is illegal and is dropped on accept.
- `req_vd_i`, `req_vs1_i`, `req_vs2_i`  in  5 each  register indices.
- `req_use_vd_i`, `req_use_vs1_i`, `req_use_vs2_i`  in  1 each  index-valid flags.
- `req_id_i`  in  ID_W  instruction id.
- `req_payload_i`  in  PLD_W  opaque payload.
- `issue_valid_o`  out  3  one-hot per unit: bit0 VFU, bit1 LSU, bit2 SLD.
- `issue_ready_i`  in  3  per-unit ready.
- `issue_id_o`  out  ID_W  head id.
- `issue_payload_o`  out  PLD_W  head payload.
- `rsp_valid_i`  in  3  per-unit completion strobe.
- `rsp_id_i`  in  3*ID_W  per-unit completion id; unit k uses bits [k*ID_W +: ID_W].
- `busy_o`  out  32  scoreboard write-pending bit per vreg.
- `idle_o`  out  1  queue empty and no outstanding ids.

## Operation
- **Queue:** circular FIFO with read/write pointers and a count.
  - Push on `req_valid_i && req_ready_o`.
  - Pop on issue handshake.
  - Push and pop in the same cycle leave the count unchanged.
  - Pointers wrap modulo DEPTH.
- **Head hazard:** the head is blocked if any of these holds: `use_vs1 && busy[vs1]`, `use_vs2 && busy[vs2]`, `use_vd && busy[vd]` (WAW). WAR is not tracked, because units read operands at issue.
- **Issue:**
  - `issue_valid_o[unit]` = queue non-empty && !hazard; all other bits are 0.
  - Handshake is `issue_valid_o[u] && issue_ready_i[u]`.
- **Scoreboard update on issue:**
  - Always: `pend[id] <= 1`.
  - If `use_vd`: `busy[vd] <= 1` and `vd_tab[id] <= vd`, `vdv_tab[id] <= 1`.
  - If `!use_vd`: `vdv_tab[id] <= 0`, so a completion for that id clears no busy bit.
- **Completion:** for each unit k with `rsp_valid_i[k]` and `pend[id_k]`:
  - `pend[id_k] <= 0`.
  - If `vdv_tab[id_k]`: `busy[vd_tab[id_k]] <= 0`.
  - A completion for a non-pending id is ignored.
  - Up to 3 completions per cycle, all applied.
- **Same cycle, same register, set and clear:** the set wins.
- **Illegal unit (3):** accepted and discarded, never enqueued.
- **Id reuse:** the upstream controller guarantees that no id is reused while it is pending. The bench asserts this.

## Timing
- **Reset** (`rst_i` high at an edge):
  - Queue empty; `busy`, `pend`, `vdv_tab` all cleared.
  - Outputs: `req_ready_o`=1, `issue_valid_o`=0, `issue_id_o`=0, `issue_payload_o`=0, `busy_o`=0, `idle_o`=1.
  - Reset mid-operation discards all queued and outstanding state; completions arriving afterwards are ignored.
- **Latency:** a request accepted at edge N can be issued at the earliest in the cycle after edge N (head registered). No same-cycle passthrough.
- **Ready:** `req_ready_o` does not depend on a same-cycle pop. When full, ready is 0 even if the head issues that cycle.
- **Valid stability:** once `issue_valid_o` asserts, it stays asserted with stable id/payload until handshake. Busy bits can only be set by issue, so a waiting head cannot become hazarded.
- **Busy clearing:** completion at edge N clears busy at edge N. A dependent head issues in the cycle after edge N (default build).
- **Back-to-back:** with no hazards and the unit ready, one instruction issues per cycle.

## Configuration
- `SPATZ_SB_BYPASS_EN`: when defined, the hazard check uses `busy_q & ~clr_vec`, where `clr_vec` is the combinational clear set from this cycle's `rsp_valid_i`.
  - A dependent head can then issue in the same cycle as the completion of its producer.
  - If that issue sets the same register being cleared, the set wins.
  - `issue_valid_o` then depends combinationally on `rsp_valid_i`/`rsp_id_i`.
- Without the macro, the hazard check uses registered busy only: one extra cycle, and no combinational rsp→issue path.

## Test plan
- **Reset:** assert `rst_i` for 2 cycles with the queue holding 3 entries → `idle_o`=1, `busy_o`=0, `issue_valid_o`=0, `req_ready_o`=1.
- **RAW stall:**
  - Push VFU id0 (vd=4), then VFU id1 (vs1=4) → id0 issues, `busy_o[4]`=1, id1 holds `issue_valid_o`=3'b000.
  - `rsp_valid_i[0]` with id0 → id1 issues the next cycle (same cycle with `SPATZ_SB_BYPASS_EN`).
- **Full queue:**
  - `issue_ready_i`=0, push 4 LSU entries → `req_ready_o`=0.
  - Raise ready → one pop per cycle; `req_ready_o`=1 the cycle after the first pop.
- **Simultaneous completions:** ids 1, 2, 3 pending with vd 8, 9, 10; all three `rsp_valid_i` bits in one cycle → `busy_o[10:8]`=0 next cycle; `idle_o`=1 once the queue is empty.
- **Spurious completion and no-vd:**
  - Completion for a non-pending id 5 → no state change.
  - Store with `use_vd`=0 issues, then completes → `busy_o` unchanged.
- **Stability and illegal unit:**
  - Head stalled on a unit not ready → id/payload constant for 10 cycles.
  - Push with `req_unit_i`=3 → accepted, never issued, count unchanged.
